// File: rtl/robertson_pkg.sv
// Shared definitions for the Robertson multiplier result collector.
package robertson_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned PROD_W    = 2 * WIDTH_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CAP_A = 2'd2,
    CAP_Q = 2'd3
  } col_state_e;

endpackage

// File: rtl/robertson_result_collector_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
  import robertson_pkg::*;
#(
  parameter int unsigned DATA_W = PROD_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_W'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) begin
      mem_d[wptr_q] = wdata;
    end
    // pointers are AW bits wide, so the increment wraps modulo DEPTH
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rdata   = mem_q[rptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/robertson_result_collector.sv
// Captures A then Q from the multiplier bus after done rises and queues {A,Q}.
// Optional ROBERTSON_COLLECT_STATS_EN adds prod_count / drop_count outputs.
module robertson_result_collector
  import robertson_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned A_DELAY = 1,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 done,
  input  logic [WIDTH-1:0]     outbus,
  output logic [2*WIDTH-1:0]   prod_data,
  output logic                 prod_valid,
  input  logic                 prod_ready,
  output logic                 busy,
  output logic                 overflow
`ifdef ROBERTSON_COLLECT_STATS_EN
  ,
  output logic [15:0]          prod_count,
  output logic [7:0]           drop_count
`endif
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  col_state_e        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_hold_q, a_hold_d;
  logic              done_q;
  logic              overflow_q, overflow_d;
  logic              done_rise;
  logic              push;
  logic              drop;

  logic [PW-1:0]     fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  always_comb begin
    done_rise = done & ~done_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_hold_d  = a_hold_q;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (done_rise) begin
          cnt_d   = 3'(A_DELAY - 1);
          state_d = (A_DELAY == 1) ? CAP_A : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = CAP_A;
        end
      end
      CAP_A: begin
        a_hold_d = outbus;
        state_d  = CAP_Q;
      end
      CAP_Q: begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // a full FIFO still accepts the push when the head leaves this cycle
    drop       = push & fifo_full & ~prod_ready;
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_hold_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_hold_q   <= a_hold_d;
      done_q     <= done;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo #(
    .DATA_W (PW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({a_hold_q, outbus}),
    .pop   (prod_ready),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    prod_valid = ~fifo_empty;
    prod_data  = (fifo_count == '0) ? '0 : fifo_rdata;
    busy       = (state_q != IDLE);
    overflow   = overflow_q;
  end

`ifdef ROBERTSON_COLLECT_STATS_EN
  logic [15:0] prod_count_q, prod_count_d;
  logic [7:0]  drop_count_q, drop_count_d;

  always_comb begin
    prod_count_d = prod_count_q + 16'(push & ~drop);
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != '1)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
    prod_count = prod_count_q;
    drop_count = drop_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      prod_count_q <= prod_count_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_robertson_result_collector.sv
// Scoreboard bench for robertson_result_collector, A_DELAY=1 and A_DELAY=3 side by side.
// Build with or without ROBERTSON_COLLECT_STATS_EN.
module tb_robertson_result_collector;

  localparam int DEPTH = 4;
  localparam int DLY0  = 1;
  localparam int DLY1  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        done;
  logic [7:0]  outbus;
  logic        rdy;
  logic [15:0] pdata  [2];
  logic        pvalid [2];
  logic        busy_o [2];
  logic        ovf    [2];
`ifdef ROBERTSON_COLLECT_STATS_EN
  logic [15:0] pcnt [2];
  logic [7:0]  dcnt [2];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  robertson_result_collector #(.WIDTH(8), .A_DELAY(DLY0), .DEPTH(DEPTH)) u_dut_d1 (
    .clk(clk), .rst(rst), .done(done), .outbus(outbus),
    .prod_data(pdata[0]), .prod_valid(pvalid[0]), .prod_ready(rdy),
    .busy(busy_o[0]), .overflow(ovf[0])
`ifdef ROBERTSON_COLLECT_STATS_EN
    , .prod_count(pcnt[0]), .drop_count(dcnt[0])
`endif
  );

  robertson_result_collector #(.WIDTH(8), .A_DELAY(DLY1), .DEPTH(DEPTH)) u_dut_d3 (
    .clk(clk), .rst(rst), .done(done), .outbus(outbus),
    .prod_data(pdata[1]), .prod_valid(pvalid[1]), .prod_ready(rdy),
    .busy(busy_o[1]), .overflow(ovf[1])
`ifdef ROBERTSON_COLLECT_STATS_EN
    , .prod_count(pcnt[1]), .drop_count(dcnt[1])
`endif
  );

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", name, i, act, exp, $time);
    end
  endtask

  // Reference model: a sequence started at cycle s captures A at s+D and Q at s+D+1,
  // and the collector is busy over cycles s+1 .. s+D+1.
  logic [15:0] mq [2][$];
  logic [15:0] sb [2][$];
  int          start [2];
  logic [7:0]  a_m [2];
  bit          ovf_m [2];
  bit          prev_done [2];
  logic [15:0] pcnt_m [2];
  logic [7:0]  dcnt_m [2];
  int          cyc = 0;
  int          dl;
  bit          bz;
  bit          mpop;
  logic [15:0] prod;

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = -1000; ovf_m[i] = 0; prev_done[i] = 0; pcnt_m[i] = 0; dcnt_m[i] = 0; a_m[i] = 0;
    end
  end

  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      dl = (i == 0) ? DLY0 : DLY1;
      bz = (cyc > start[i]) && (cyc <= start[i] + dl + 1);
      chk("busy", i, 32'(busy_o[i]), 32'(bz));
      chk("valid", i, 32'(pvalid[i]), 32'(mq[i].size() != 0));
      chk("head", i, 32'(pdata[i]), (mq[i].size() != 0) ? 32'(mq[i][0]) : 32'd0);
      chk("overflow", i, 32'(ovf[i]), 32'(ovf_m[i]));
`ifdef ROBERTSON_COLLECT_STATS_EN
      chk("prod_count", i, 32'(pcnt[i]), 32'(pcnt_m[i]));
      chk("drop_count", i, 32'(dcnt[i]), 32'(dcnt_m[i]));
`endif
      if (rst) begin
        mq[i].delete();
        sb[i].delete();
        start[i] = -1000; ovf_m[i] = 0; prev_done[i] = 0; pcnt_m[i] = 0; dcnt_m[i] = 0;
      end else begin
        mpop = (mq[i].size() != 0) && rdy;
        if (cyc == start[i] + dl) a_m[i] = outbus;
        if (mpop) void'(mq[i].pop_front());
        if (cyc == start[i] + dl + 1) begin
          prod = {a_m[i], outbus};
          if (mq[i].size() == DEPTH) begin
            ovf_m[i] = 1;
            if (dcnt_m[i] != 8'hFF) dcnt_m[i] = dcnt_m[i] + 8'd1;
          end else begin
            mq[i].push_back(prod);
            sb[i].push_back(prod);
            pcnt_m[i] = pcnt_m[i] + 16'd1;
          end
        end
        if (done && !prev_done[i] && !bz) start[i] = cyc;
        prev_done[i] = done;
      end
    end
    cyc++;
  end

  // Monitor: every handshake pops the scoreboard and compares the product.
  logic [15:0] exp_v;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pvalid[i] === 1'b1 && rdy === 1'b1) begin
        if (sb[i].size() == 0) begin
          chk("unexpected_pop", i, 32'(pdata[i]), 32'hFFFF_FFFF);
        end else begin
          exp_v = sb[i].pop_front();
          chk("pop_data", i, 32'(pdata[i]), 32'(exp_v));
        end
      end
    end
  end

  bit rdy_base;

  task automatic step(input bit d, input logic [7:0] b, input bit r, input bit rs);
    done = d; outbus = b; rdy = r; rst = rs;
    @(posedge clk);
    #1;
  endtask

  // done rises at k=0; A is driven at k=dly and Q at k=dly+1
  task automatic send(input logic [7:0] a, input logic [7:0] q, input int dly,
                      input bit glitch, input bit rdy_capq, input bit rst_capa);
    logic [7:0] b;
    step(1'b1, 8'($urandom), rdy_base, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      b = (k == dly) ? a : (k == dly + 1) ? q : 8'($urandom);
      step(glitch && (k == dly), b, (rdy_capq && (k == dly + 1)) ? 1'b1 : rdy_base,
           rst_capa && (k == dly));
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom), rdy_base, 1'b0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < 2; k++) step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  initial begin
    done = 0; outbus = 0; rdy = 0; rst = 1;
    @(posedge clk);
    #1;
    do_reset();
    rdy_base = 1;
    idle(3);
    send(8'hFF, 8'hF1, DLY0, 0, 0, 0);
    idle(3);

    rdy_base = 0;
    send(8'h00, 8'h19, DLY0, 0, 0, 0);
    send(8'hFF, 8'hF1, DLY0, 0, 0, 0);
    send(8'h7F, 8'h01, DLY0, 0, 0, 0);
    send(8'hC0, 8'h00, DLY0, 0, 0, 0);
    idle(4);
    send(8'h12, 8'h34, DLY0, 0, 0, 0);
    idle(2);
    rdy_base = 1;
    idle(8);

    do_reset();
    rdy_base = 0;
    for (int n = 0; n < 4; n++) send(8'(n), 8'(n * 7), DLY0, 0, 0, 0);
    send(8'hAB, 8'hCD, DLY0, 0, 1, 0);
    rdy_base = 1;
    idle(8);

    send(8'h01, 8'h02, DLY1, 1, 0, 0);
    idle(4);
    send(8'h55, 8'h66, DLY0, 0, 0, 1);
    idle(2);
    send(8'h00, 8'h64, DLY0, 0, 0, 0);
    idle(4);

    do_reset();
    rdy_base = 0;
    send(8'hFF, 8'hF1, DLY1, 0, 0, 0);
    send(8'h00, 8'h19, DLY1, 0, 0, 0);
    send(8'h7F, 8'h01, DLY1, 0, 0, 0);
    send(8'hC0, 8'h00, DLY1, 0, 0, 0);
    send(8'h11, 8'h22, DLY1, 0, 0, 0);
    idle(2);
    rdy_base = 1;
    idle(8);

    for (int k = 0; k < 500; k++) begin
      step($urandom_range(0, 3) == 0, 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 99) == 0);
    end
    rdy_base = 1;
    idle(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
